// File: rtl/wfg_drive_spi_if.sv
// AXI-Stream sample channel carrying 18-bit signed samples from a wfg_stim_* source
// into wfg_drive_spi.
interface wfg_drive_spi_if;
  logic        tready;
  logic        tvalid;
  logic [17:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/wfg_drive_spi.sv
// AXI-Stream sink that serialises one sign-extended sample per frame as a TX-only
// CPHA=0 SPI master toward an external DAC. All pin outputs are registered.
module wfg_drive_spi #(
  parameter int unsigned DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  wfg_drive_spi_if.slave    stim_s,
  input  logic              ctrl_en_q_i,
  input  logic              ctrl_cpol_q_i,
  input  logic              ctrl_lsbfirst_q_i,
  input  logic [1:0]        ctrl_dff_q_i,
  input  logic [DIV_W-1:0]  clkcfg_div_q_i,
  output logic              spi_sclk_o,
  output logic              spi_cs_o,
  output logic              spi_sdo_o
);

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [31:0]      data_q, data_d;
  logic             lsb_q, lsb_d;
  logic [1:0]       dff_q, dff_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpol_q, cpol_d;
  logic             tready_q, tready_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             handshake;
  logic             cnt_done;
  logic [31:0]      sample_ext;

  function automatic logic [31:0] sign_ext(input logic [17:0] s);
    return {{14{s[17]}}, s};
  endfunction

  function automatic logic [4:0] last_bit(input logic [1:0] dff);
    return {dff, 3'b111};
  endfunction

  // The bit counter always runs N-1 downto 0; LSB-first mirrors it into the word.
  function automatic logic pick_bit(input logic [31:0] w, input logic lsb,
                                    input logic [1:0] dff, input logic [4:0] b);
    logic [4:0] idx;
    idx = lsb ? (last_bit(dff) - b) : b;
    return w[idx];
  endfunction

  assign handshake  = stim_s.tvalid & tready_q;
  assign cnt_done   = (cnt_q == div_q);
  assign sample_ext = sign_ext(stim_s.tdata);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    lsb_d    = lsb_q;
    dff_d    = dff_q;
    div_d    = div_q;
    cpol_d   = cpol_q;
    tready_d = 1'b0;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    sdo_d    = sdo_q;

    case (state_q)
      IDLE: begin
        tready_d = ctrl_en_q_i;
        cs_d     = 1'b1;
        sdo_d    = 1'b0;
        sclk_d   = ctrl_cpol_q_i;
        if (handshake) begin
          data_d   = sample_ext;
          lsb_d    = ctrl_lsbfirst_q_i;
          dff_d    = ctrl_dff_q_i;
          div_d    = clkcfg_div_q_i;
          cpol_d   = ctrl_cpol_q_i;
          state_d  = CS_SETUP;
          cnt_d    = '0;
          half_d   = 1'b0;
          bitcnt_d = last_bit(ctrl_dff_q_i);
          tready_d = 1'b0;
          cs_d     = 1'b0;
          sdo_d    = pick_bit(sample_ext, ctrl_lsbfirst_q_i, ctrl_dff_q_i,
                              last_bit(ctrl_dff_q_i));
        end
      end

      CS_SETUP: begin
        if (cnt_done) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      // First half of each bit holds sclk at idle, second half drives the leading level.
      SHIFT: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
            sclk_d = ~cpol_q;
          end else begin
            half_d = 1'b0;
            sclk_d = cpol_q;
            if (bitcnt_q == 5'd0) begin
              state_d = CS_HOLD;
            end else begin
              bitcnt_d = bitcnt_q - 5'd1;
              sdo_d    = pick_bit(data_q, lsb_q, dff_q, bitcnt_q - 5'd1);
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      CS_HOLD: begin
        if (cnt_done) begin
          state_d  = IDLE;
          cnt_d    = '0;
          cs_d     = 1'b1;
          sdo_d    = 1'b0;
          sclk_d   = ctrl_cpol_q_i;
          tready_d = ctrl_en_q_i;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sdo_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      half_q   <= 1'b0;
      bitcnt_q <= '0;
      data_q   <= '0;
      lsb_q    <= 1'b0;
      dff_q    <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      tready_q <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      lsb_q    <= lsb_d;
      dff_q    <= dff_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      tready_q <= tready_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
    end
  end

  assign stim_s.tready = tready_q;
  assign spi_sclk_o    = sclk_q;
  assign spi_cs_o      = cs_q;
  assign spi_sdo_o     = sdo_q;

endmodule
